// File: rtl/key_event_pkg.sv
// Shared types and widths for the key event generator.
package key_event_pkg;

    localparam int unsigned COUNT_W = 8;
    localparam int unsigned CNT_W   = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        HOLD   = 2'b01,
        REPEAT = 2'b10
    } state_t;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running power-of-two prescaler; tick_c is high on the last count of each period.
module tick_prescaler #(
    parameter int unsigned TICK_BITS = 19
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    output logic tick_c
);

    logic [TICK_BITS-1:0] count_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + TICK_BITS'(1);
        end
    end

    assign tick_c = &count_q;

endmodule

// File: rtl/key_event_gen.sv
// Turns a debounced key level into press/release/auto-repeat pulses and an event counter.
module key_event_gen
    import key_event_pkg::*;
#(
    parameter int unsigned TICK_BITS    = 19,
    parameter int unsigned HOLD_TICKS   = 50,
    parameter int unsigned REPEAT_TICKS = 10
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               level_in,
    input  logic               enable,
    output logic               press,
    output logic               release_p,
    output logic               repeat_p,
    output logic               event_p,
    output logic               held,
    output logic [COUNT_W-1:0] event_count
);

    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_TICKS - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_TICKS - 1);

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               lvl_q;
    logic               tick_c;
    logic               rise_c;
    logic               fall_c;
    logic               busy_c;
    logic               at_last_c;
    logic               press_set_c;
    logic               release_set_c;
    logic               repeat_set_c;
    logic               clear_c;

    tick_prescaler #(
        .TICK_BITS (TICK_BITS)
    ) u_prescaler (
        .clock  (clock),
        .reset  (reset),
        .clear  (clear_c),
        .tick_c (tick_c)
    );

    // Decide this edge's pulses; release beats a coincident repeat expiry.
    always_comb begin
        rise_c        = level_in & ~lvl_q;
        fall_c        = ~level_in & lvl_q;
        busy_c        = (state_q == HOLD) || (state_q == REPEAT);
        at_last_c     = (state_q == HOLD) ? (cnt_q == HOLD_LAST) : (cnt_q == REPEAT_LAST);
        press_set_c   = enable & ~busy_c & rise_c;
        release_set_c = enable & busy_c & fall_c;
        repeat_set_c  = enable & busy_c & ~fall_c & tick_c & at_last_c;
        clear_c       = press_set_c | repeat_set_c;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            lvl_q       <= 1'b0;
            press       <= 1'b0;
            release_p   <= 1'b0;
            repeat_p    <= 1'b0;
            event_p     <= 1'b0;
            held        <= 1'b0;
            event_count <= '0;
        end else begin
            lvl_q     <= level_in;
            press     <= press_set_c;
            release_p <= release_set_c;
            repeat_p  <= repeat_set_c;
            event_p   <= press_set_c | repeat_set_c;
            if (press_set_c || repeat_set_c) begin
                event_count <= event_count + COUNT_W'(1);
            end

            if (!enable) begin
                state_q <= IDLE;
                cnt_q   <= '0;
                held    <= 1'b0;
            end else if (press_set_c) begin
                state_q <= HOLD;
                cnt_q   <= '0;
                held    <= 1'b1;
            end else if (release_set_c) begin
                state_q <= IDLE;
                held    <= 1'b0;
            end else if (repeat_set_c) begin
                state_q <= REPEAT;
                cnt_q   <= '0;
                held    <= 1'b1;
            end else if (busy_c) begin
                if (tick_c) begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
                held <= 1'b1;
            end else begin
                // Also folds the unused 2'b11 encoding back to IDLE.
                state_q <= IDLE;
                held    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_key_event_gen.sv
// Self-checking bench for key_event_gen: vector table, corner sequences, random vs reference model.
module tb_key_event_gen;

    localparam int unsigned TB_TICK_BITS = 3;
    localparam int unsigned TB_HOLD      = 3;
    localparam int unsigned TB_REP       = 2;
    localparam int unsigned PERIOD       = 1 << TB_TICK_BITS;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       level_in = 1'b0;
    logic       enable = 1'b1;
    logic       press, release_p, repeat_p, event_p, held;
    logic [7:0] event_count;

    int total = 0;
    int bad   = 0;

    // Reference model state: edges since last press/repeat and the distance to the next repeat.
    bit          m_prev;
    bit          m_hold;
    int          m_since;
    int          m_due;
    logic [7:0]  m_cnt;
    logic [12:0] m_exp;

    key_event_gen #(
        .TICK_BITS    (TB_TICK_BITS),
        .HOLD_TICKS   (TB_HOLD),
        .REPEAT_TICKS (TB_REP)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .level_in    (level_in),
        .enable      (enable),
        .press       (press),
        .release_p   (release_p),
        .repeat_p    (repeat_p),
        .event_p     (event_p),
        .held        (held),
        .event_count (event_count)
    );

    always #5 clock = ~clock;

    function automatic logic [12:0] mk(input bit p, input bit r, input bit q,
                                       input bit e, input bit h, input int c);
        logic [7:0] c8;
        c8 = 8'(c);
        return {p, r, q, e, h, c8};
    endfunction

    task automatic check(input string name, input logic [12:0] want);
        logic [12:0] got;
        got = {press, release_p, repeat_p, event_p, held, event_count};
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got press/rel/rep/evt/held=%05b count=%0d, want %05b count=%0d",
                     name, got[12:8], got[7:0], want[12:8], want[7:0]);
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    task automatic model_step(input logic rst, input logic lvl, input logic en);
        bit p, r, q, rise, fall;
        p = 0; r = 0; q = 0;
        if (!rst) begin
            m_prev = 0;
            m_hold = 0;
            m_cnt  = 8'd0;
        end else begin
            rise   = lvl && !m_prev;
            fall   = !lvl && m_prev;
            m_prev = lvl;
            if (!en) begin
                m_hold = 0;
            end else if (!m_hold) begin
                if (rise) begin
                    p = 1; m_hold = 1; m_since = 0; m_due = TB_HOLD * PERIOD;
                end
            end else if (fall) begin
                r = 1; m_hold = 0;
            end else begin
                m_since++;
                if (m_since == m_due) begin
                    q = 1; m_since = 0; m_due = TB_REP * PERIOD;
                end
            end
            if (p || q) m_cnt = m_cnt + 8'd1;
        end
        m_exp = {p, r, q, p | q, m_hold, m_cnt};
    endtask

    // Drive one edge's inputs, advance the model, and compare shortly after the edge.
    task automatic apply(input logic rst, input logic lvl, input logic en);
        reset    = rst;
        level_in = lvl;
        enable   = en;
        @(posedge clock);
        model_step(rst, lvl, en);
        #1;
        check("model", m_exp);
    endtask

    typedef struct {
        logic        rst;
        logic        lvl;
        logic        en;
        logic [12:0] want;
    } vec_t;

    vec_t vecs[13];

    initial begin
        int   reps[$];
        int   n;
        logic lvl, en, rst;

        vecs[0]  = '{1'b0, 1'b0, 1'b1, mk(0,0,0,0,0,0)};
        vecs[1]  = '{1'b1, 1'b0, 1'b1, mk(0,0,0,0,0,0)};
        vecs[2]  = '{1'b1, 1'b1, 1'b1, mk(1,0,0,1,1,1)};
        vecs[3]  = '{1'b1, 1'b1, 1'b1, mk(0,0,0,0,1,1)};
        vecs[4]  = '{1'b1, 1'b0, 1'b1, mk(0,1,0,0,0,1)};
        vecs[5]  = '{1'b1, 1'b0, 1'b1, mk(0,0,0,0,0,1)};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, mk(0,0,0,0,0,1)};
        vecs[7]  = '{1'b1, 1'b1, 1'b1, mk(0,0,0,0,0,1)};
        vecs[8]  = '{1'b1, 1'b0, 1'b1, mk(0,0,0,0,0,1)};
        vecs[9]  = '{1'b1, 1'b1, 1'b1, mk(1,0,0,1,1,2)};
        vecs[10] = '{1'b1, 1'b1, 1'b0, mk(0,0,0,0,0,2)};
        vecs[11] = '{1'b0, 1'b1, 1'b1, mk(0,0,0,0,0,0)};
        vecs[12] = '{1'b1, 1'b1, 1'b1, mk(1,0,0,1,1,1)};

        for (int i = 0; i < 13; i++) begin
            apply(vecs[i].rst, vecs[i].lvl, vecs[i].en);
            check($sformatf("vec%0d", i), vecs[i].want);
        end

        // Long hold: repeats at E+24, E+40, E+56, release at E+70.
        apply(0, 0, 1);
        apply(1, 1, 1);
        check("lh_press", mk(1,0,0,1,1,1));
        for (int i = 1; i < 70; i++) begin
            apply(1, 1, 1);
            if (repeat_p) reps.push_back(i);
        end
        apply(1, 0, 1);
        check("lh_release", mk(0,1,0,0,0,4));
        check_int("lh_nrep", reps.size(), 3);
        for (int k = 0; k < 3; k++) begin
            if (k < reps.size()) check_int($sformatf("lh_rep%0d_edge", k), reps[k], 24 + 16 * k);
        end

        // Release coinciding with the first repeat expiry.
        apply(0, 0, 1);
        apply(1, 1, 1);
        for (int i = 1; i < 24; i++) apply(1, 1, 1);
        apply(1, 0, 1);
        check("expiry_release", mk(0,1,0,0,0,1));

        // Enable gating while the key stays held.
        apply(0, 0, 1);
        apply(1, 1, 1);
        n = 0;
        for (int i = 1; i <= 60; i++) begin
            apply(1, 1, (i >= 10 && i < 20) ? 1'b0 : 1'b1);
            if (press || repeat_p) n++;
        end
        check_int("gate_events", n, 0);
        check("gate_idle", mk(0,0,0,0,0,1));
        apply(1, 0, 1);
        check("gate_norelease", mk(0,0,0,0,0,1));
        apply(1, 1, 1);
        check("gate_repress", mk(1,0,0,1,1,2));

        // Reset in the middle of auto-repeat.
        apply(0, 0, 1);
        apply(1, 1, 1);
        for (int i = 1; i < 30; i++) apply(1, 1, 1);
        apply(0, 1, 1);
        check("rst_mid_a", mk(0,0,0,0,0,0));
        apply(0, 1, 1);
        check("rst_mid_b", mk(0,0,0,0,0,0));
        apply(1, 1, 1);
        check("rst_mid_press", mk(1,0,0,1,1,1));

        // Event counter wrap.
        apply(0, 0, 1);
        for (int t = 0; t < 256; t++) begin
            apply(1, 1, 1);
            apply(1, 0, 1);
        end
        check("wrap_256", mk(0,1,0,0,0,0));
        apply(1, 1, 1);
        check("wrap_257", mk(1,0,0,1,1,1));

        // Random traffic against the reference model.
        apply(0, 0, 1);
        lvl = 0; en = 1;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 39) == 0) lvl = ~lvl;
            if (en) begin
                if ($urandom_range(0, 99) == 0) en = 0;
            end else if ($urandom_range(0, 7) == 0) begin
                en = 1;
            end
            rst = ($urandom_range(0, 799) == 0) ? 1'b0 : 1'b1;
            apply(rst, lvl, en);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/key_event_gen.md
Name: key_event_gen

Overview:
- Consumer end of the debounced-button interface. Takes the clean level from the button debouncer and converts it into single-cycle events for the CPU/datapath:
  - press pulse
  - release pulse
  - auto-repeat pulses while the key is held
  - wrapping event counter
- Sits between the debouncer output and any logic that steps on key presses (single-step clock, register select, display page).

Parameters:
- TICK_BITS, 19: prescaler width. The tick period is 2^TICK_BITS clocks.
- HOLD_TICKS, 50: ticks of continuous hold after the press before the first repeat. Legal range is 1..255.
- REPEAT_TICKS, 10: ticks between consecutive repeats. Legal range is 1..255.

Ports:
- clock  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-low reset. Sampled on the clock rising edge; 0 means reset.
- level_in  in  1  debounced key level; 1 means the key is held.
- enable  in  1  1 means events are generated; 0 means the block is held idle.
- press  out  1  one-cycle pulse on the key-down edge.
- release  out  1  one-cycle pulse on the key-up edge.
- repeat_p  out  1  one-cycle pulse per auto-repeat.
- event  out  1  press OR repeat_p, registered and aligned with them.
- held  out  1  1 while the FSM is in HOLD or REPEAT.
- event_count  out  8  count of event pulses; wraps 255 to 0.

Behaviour:
- Reset (reset=0 at an edge): every output is 0, event_count=0, FSM=IDLE, prescaler=0, hold/repeat counter=0, lvl_q=0.
- Reset overrides every other input. Reset mid-hold or mid-repeat aborts with no release pulse.
- Edge detection:
  - lvl_q<=level_in every edge, including when enable=0.
  - rise = level_in & ~lvl_q; fall = ~level_in & lvl_q.
  - Because lvl_q resets to 0, a key held through reset produces a press on the first edge after reset deasserts (enable=1).
- Prescaler: free-running TICK_BITS counter. tick = AND of all prescaler bits, combinational.
  - The prescaler clears to 0 on the edge that registers press.
  - It also clears on the edge that registers repeat_p.
- Pulse outputs are registered and high for exactly one cycle, starting at the deciding edge. Latency from level_in change to pulse is 1 edge.
- FSM states:
  - IDLE: on rise and enable=1, go to HOLD, press<=1, cnt<=0, prescaler<=0.
  - HOLD:
    - On fall, go to IDLE, release<=1.
    - Else on tick: if cnt==HOLD_TICKS-1, go to REPEAT, repeat_p<=1, cnt<=0, prescaler<=0; otherwise cnt<=cnt+1.
  - REPEAT:
    - On fall, go to IDLE, release<=1.
    - Else on tick: if cnt==REPEAT_TICKS-1, repeat_p<=1, cnt<=0, prescaler<=0; otherwise cnt<=cnt+1.
- Simultaneous fall and tick expiry on the same edge: release wins; no repeat_p.
- enable=0 at any edge:
  - FSM goes to IDLE; cnt<=0; press, release and repeat_p are all 0.
  - A key already held when enable rises produces no press, because lvl_q is tracking. The key must be released and pressed again.
- event = press | repeat_p; event_count increments by 1 on each edge that registers event.
- held = 1 in HOLD and REPEAT, 0 in IDLE. It is registered with the state.
- cnt is 8 bits; HOLD_TICKS and REPEAT_TICKS are compared in 8 bits.

Decomposition:
- Package key_event_pkg holds:
  - the state localparams IDLE=2'b00, HOLD=2'b01, REPEAT=2'b10 (2'b11 decodes to IDLE);
  - the event_count width constant (8).
- One natural sub-module, tick_prescaler: a TICK_BITS counter with a synchronous clear input and a tick output. The same block is reusable by the debouncer.

Test Plan:
All scenarios use TICK_BITS=3, HOLD_TICKS=3, REPEAT_TICKS=2, enable=1 unless stated. E is the press edge.
- Short tap: level_in=1 for 10 cycles, then 0 -> press at E; release 10 edges later; no repeat_p; event_count=1.
- Long hold: level_in=1 for 70 cycles -> press at E; repeat_p at E+24, E+40 and E+56; release at E+70; event_count=4.
- Release on expiry: level_in falls exactly on edge E+24 -> release=1 and repeat_p=0 on that edge; event_count=1.
- Enable gating: drop enable at E+10 while held, raise it at E+20, keep the key held to E+60 -> no repeat_p and no further press. Release and press again -> a new press fires.
- Reset mid-repeat: reset=0 at E+30 for 2 cycles with the key held -> all outputs 0 and event_count=0; press on the first edge after reset returns to 1.
- Counter wrap: 256 taps -> event_count returns to 0; 257th tap -> event_count=1.
